// File: rtl/seq_div32.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned.
// Ports: clk, rst_n; start/is_signed/dividend/divisor in; busy/done/quotient/remainder/div_zero out.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dd_abs;
  logic [WIDTH-1:0] w_dv_abs;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_dv_neg = is_signed & divisor[WIDTH-1];
  assign w_dd_abs = w_dd_neg ? -dividend : dividend;
  assign w_dv_abs = w_dv_neg ? -divisor : divisor;

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_dvs});
  // Difference always fits in WIDTH bits when w_ge holds.
  assign w_sub = w_sh[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_qneg <= w_dd_neg ^ w_dv_neg;
            r_rneg <= w_dd_neg;
            r_dvs  <= w_dv_abs;
            r_rem  <= '0;
            r_cnt  <= CW'(WIDTH);
            if (divisor == '0) begin
              // Raw dividend kept for the divide-by-zero remainder.
              r_quo   <= dividend;
              r_state <= S_FIN;
            end else begin
              r_quo   <= w_dd_abs;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_sub : w_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_q     <= r_qneg ? -r_quo : r_quo;
          r_r     <= r_rneg ? -r_rem : r_rem;
          r_dz    <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FIN: begin
          r_q     <= '1;
          r_r     <= r_quo;
          r_dz    <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_div32.sv
// Bench for seq_div32: vector table, random ops vs arithmetic model,
// and handshake / reset sequences.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int errs = 0;
  int checks = 0;

  seq_div32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .is_signed(is_signed), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] dv;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, b,
                       input logic s,
                       output logic [31:0] q, r,
                       output logic dz);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
    end
  endtask

  // Drive start for one edge; returns at the negedge after the start edge.
  task automatic launch(input logic [31:0] a, b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_chk(input string nm,
                         input logic [31:0] a, b,
                         input logic s);
    logic [31:0] eq, er;
    logic        edz;
    int          lat;
    model(a, b, s, eq, er, edz);
    launch(a, b, s);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({nm, "_lat"}, 32'(lat), edz ? 32'd1 : 32'd33);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dz"}, 32'(div_zero), 32'(edz));
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic        edz, s;
    int          lat;
    int          seen;

    tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    tbl[1] = '{-32'd100, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[2] = '{32'd100, -32'd7, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0};
    tbl[3] = '{-32'd100, -32'd7, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0};
    tbl[4] = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    tbl[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0};
    tbl[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].dd, tbl[i].dv, tbl[i].s);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), tbl[i].dz ? 32'd1 : 32'd33);
      chk($sformatf("v%0d_q", i), quotient, tbl[i].q);
      chk($sformatf("v%0d_r", i), remainder, tbl[i].r);
      chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(tbl[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 5)
        0: b = b & 32'hFF;
        1: b = (i % 10 == 1) ? 32'd0 : b;
        2: a = a & 32'hFFFF;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      run_chk($sformatf("rnd%0d", i), a, b, s);
    end

    // start while busy is ignored
    model(32'd1000, 32'd33, 1'b0, eq, er, edz);
    launch(32'd1000, 32'd33, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd23);
    chk("ign_q", quotient, eq);
    chk("ign_r", remainder, er);
    chk("ign_dz", 32'(div_zero), 32'(edz));

    // back-to-back: start in the done cycle
    launch(32'd77, 32'd5, 1'b0);
    wait_done(lat);
    chk("b2b1_q", quotient, 32'd15);
    chk("b2b1_r", remainder, 32'd2);
    dividend = -32'd50; divisor = 32'd6; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(lat);
    chk("b2b2_lat", 32'(lat), 32'd33);
    chk("b2b2_q", quotient, 32'hFFFFFFF8);
    chk("b2b2_r", remainder, 32'hFFFFFFFE);

    // async reset mid-run
    launch(32'd999, 32'd0, 1'b0);
    wait_done(lat);
    launch(32'd12345, 32'd67, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst_nodone", 32'(seen), 32'd0);
    run_chk("post_rst", 32'd12345, 32'd67, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
